// File: rtl/fpa_pkg.sv
// Shared types and constants for the array-reduction sequencer in front of the FPA core.
package fpa_pkg;

    typedef enum logic [1:0] {
        FPA_ADD  = 2'b00,
        FPA_SUB  = 2'b01,
        FPA_RSV2 = 2'b10,
        FPA_RSV3 = 2'b11
    } fpa_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        DONE  = 2'b11
    } ctrl_state_e;

    localparam logic [31:0] FP_ONE = 32'h3F800000;

    function automatic logic is_reserved_op(input logic [1:0] op);
        return (op == FPA_RSV2) || (op == FPA_RSV3);
    endfunction

endpackage

// File: rtl/fpa_reduce_ctrl.sv
// Serial reduction sequencer: acc = x0, then acc = acc op xi through one shared FPA core,
// with sticky core flags and a response timeout.
module fpa_reduce_ctrl
    import fpa_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int N          = 9,
    parameter int TIMEOUT    = 64
) (
    input  logic                        iCLK,
    input  logic                        iRESET,
    input  logic                        iEN,
    input  logic                        iSTART,
    input  logic [(N+1)*DATA_WIDTH-1:0] iNUMBERS,
    input  logic [1:0]                  iOPERATION,
    output logic                        oBUSY,
    output logic                        oFPA_REQ,
    output logic [DATA_WIDTH-1:0]       oFPA_A,
    output logic [DATA_WIDTH-1:0]       oFPA_B,
    output logic [1:0]                  oFPA_OPERATION,
    input  logic                        iFPA_VALID,
    input  logic [DATA_WIDTH-1:0]       iFPA_RESULT,
    input  logic                        iFPA_OVERFLOW,
    input  logic                        iFPA_UNDERFLOW,
    input  logic                        iFPA_EXCEPTION,
    output logic [DATA_WIDTH-1:0]       oRESULT,
    output logic                        oOVERFLOW,
    output logic                        oUNDERFLOW,
    output logic                        oEXCEPTION,
    output logic                        oDATA_VALID
);

    localparam int IDX_W = $clog2(N + 1);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    ctrl_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] x_q [N+1];
    logic [DATA_WIDTH-1:0] x_d [N+1];
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [1:0]            op_q, op_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  exc_q, exc_d;

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            state_q <= IDLE;
            for (int i = 0; i <= N; i++) x_q[i] <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            for (int i = 0; i <= N; i++) x_q[i] <= x_d[i];
            acc_q   <= acc_d;
            res_q   <= res_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            exc_q   <= exc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        acc_d   = acc_q;
        res_d   = res_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        exc_d   = exc_q;

        case (state_q)
            IDLE: begin
                if (iSTART && iEN) begin
                    for (int i = 0; i <= N; i++) x_d[i] = iNUMBERS[i*DATA_WIDTH +: DATA_WIDTH];
                    op_d  = iOPERATION;
                    acc_d = iNUMBERS[DATA_WIDTH-1:0];
                    idx_d = IDX_W'(1);
                    res_d = '0;
                    ovf_d = 1'b0;
                    unf_d = 1'b0;
                    exc_d = 1'b0;
                    if (is_reserved_op(iOPERATION)) begin
                        exc_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // A response arriving on the timeout cycle still counts as a normal response.
                if (iFPA_VALID) begin
                    acc_d = iFPA_RESULT;
                    ovf_d = ovf_q | iFPA_OVERFLOW;
                    unf_d = unf_q | iFPA_UNDERFLOW;
                    exc_d = exc_q | iFPA_EXCEPTION;
                    if (iFPA_EXCEPTION || idx_q == IDX_LAST) begin
                        res_d   = iFPA_RESULT;
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ISSUE;
                    end
                end else if (cnt_d == CNT_LIMIT) begin
                    exc_d   = 1'b1;
                    res_d   = acc_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Core operands come straight from state, so they stay stable for the whole ISSUE/WAIT window.
    assign oFPA_A         = acc_q;
    assign oFPA_B         = x_q[idx_q];
    assign oFPA_OPERATION = op_q;
    assign oFPA_REQ       = (state_q == ISSUE);
    assign oBUSY          = (state_q != IDLE);
    assign oDATA_VALID    = (state_q == DONE);
    assign oRESULT        = res_q;
    assign oOVERFLOW      = ovf_q;
    assign oUNDERFLOW     = unf_q;
    assign oEXCEPTION     = exc_q;

endmodule

// File: tb/tb_fpa_reduce_ctrl.sv
// Randomized bench for fpa_reduce_ctrl with a behavioural FPA core (programmable latency, flag injection)
// and a job-level reference model working on plain integers.
module tb_fpa_reduce_ctrl;

    localparam int DW      = 32;
    localparam int N       = 9;
    localparam int TIMEOUT = 64;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 en, start;
    logic [(N+1)*DW-1:0]  numbers;
    logic [1:0]           op_in;
    logic                 busy, fpa_req, data_valid;
    logic [DW-1:0]        fpa_a, fpa_b, result;
    logic [1:0]           fpa_op;
    logic                 fpa_valid, fpa_ovf, fpa_unf, fpa_exc;
    logic [DW-1:0]        fpa_result;
    logic                 ovf, unf, exc;

    always #5 clk = ~clk;

    fpa_reduce_ctrl #(.DATA_WIDTH(DW), .N(N), .TIMEOUT(TIMEOUT)) dut (
        .iCLK(clk), .iRESET(rst), .iEN(en), .iSTART(start), .iNUMBERS(numbers),
        .iOPERATION(op_in), .oBUSY(busy), .oFPA_REQ(fpa_req), .oFPA_A(fpa_a),
        .oFPA_B(fpa_b), .oFPA_OPERATION(fpa_op), .iFPA_VALID(fpa_valid),
        .iFPA_RESULT(fpa_result), .iFPA_OVERFLOW(fpa_ovf), .iFPA_UNDERFLOW(fpa_unf),
        .iFPA_EXCEPTION(fpa_exc), .oRESULT(result), .oOVERFLOW(ovf),
        .oUNDERFLOW(unf), .oEXCEPTION(exc), .oDATA_VALID(data_valid)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Exact float encoding for integers with magnitude below 2^23.
    function automatic logic [31:0] int_to_fp(input int v);
        int m, p;
        logic [31:0] r;
        if (v == 0) return 32'h0;
        m = (v < 0) ? -v : v;
        p = 0;
        for (int k = 0; k < 24; k++) if (m >= (1 << k)) p = k;
        r[31]    = (v < 0);
        r[30:23] = 8'(127 + p);
        r[22:0]  = 23'((m << (23 - p)) & 32'h007F_FFFF);
        return r;
    endfunction

    function automatic int fp_to_int(input logic [31:0] f);
        int e, mag;
        if (f[30:23] == 8'h0) return 0;
        e   = int'(f[30:23]) - 127;
        mag = int'({1'b1, f[22:0]}) >> (23 - e);
        return f[31] ? -mag : mag;
    endfunction

    // Core model configuration and observation
    int          core_lat;
    bit          core_never;
    int          ovf_step, unf_step, exc_step;
    int          step;
    bit          late_pulse;
    logic [31:0] cap_a, cap_b;
    logic [1:0]  cap_op;
    logic [31:0] got_a_q[$], got_b_q[$];

    initial begin
        int cd;
        cd = -1;
        fpa_valid = 0; fpa_result = '0; fpa_ovf = 0; fpa_unf = 0; fpa_exc = 0;
        forever begin
            @(posedge clk); #1;
            fpa_valid = 0; fpa_ovf = 0; fpa_unf = 0; fpa_exc = 0;
            if (late_pulse) begin
                late_pulse = 0;
                fpa_valid  = 1;
                fpa_result = $urandom;
                fpa_ovf    = 1; fpa_unf = 1; fpa_exc = 1;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    fpa_valid  = 1;
                    fpa_result = int_to_fp((cap_op == 2'b01) ? fp_to_int(cap_a) - fp_to_int(cap_b)
                                                            : fp_to_int(cap_a) + fp_to_int(cap_b));
                    fpa_ovf    = (step == ovf_step);
                    fpa_unf    = (step == unf_step);
                    fpa_exc    = (step == exc_step);
                    cd = -1;
                end
            end
            @(negedge clk);
            if (fpa_req === 1'b1 && !rst) begin
                step++;
                cap_a = fpa_a; cap_b = fpa_b; cap_op = fpa_op;
                got_a_q.push_back(fpa_a);
                got_b_q.push_back(fpa_b);
                cd = core_never ? -1 : core_lat;
            end
        end
    end

    int xi [N+1];

    task automatic load_numbers();
        for (int i = 0; i <= N; i++) numbers[i*DW +: DW] = int_to_fp(xi[i]);
    endtask

    task automatic run_job(input string name, input logic [1:0] op, input int lat,
                           input int o_s, input int u_s, input int e_s,
                           input bit never, input bit poke);
        int acc, exp_req, exp_lat, cyc;
        bit e_ovf, e_unf, e_exc;
        logic [31:0] exp_res, held;
        logic [31:0] exp_a_q[$], exp_b_q[$];

        core_lat = lat; core_never = never;
        ovf_step = o_s; unf_step = u_s; exc_step = e_s;
        step = 0;
        got_a_q.delete(); got_b_q.delete();

        acc = xi[0]; exp_req = 0; e_ovf = 0; e_unf = 0; e_exc = 0;
        if (op[1]) begin
            e_exc = 1; exp_res = 32'h0; exp_lat = 1;
        end else if (never) begin
            exp_req = 1; e_exc = 1; exp_res = int_to_fp(acc);
            exp_a_q.push_back(int_to_fp(acc)); exp_b_q.push_back(int_to_fp(xi[1]));
            exp_lat = 1 + TIMEOUT + 1;
        end else begin
            for (int i = 1; i <= N; i++) begin
                exp_req++;
                exp_a_q.push_back(int_to_fp(acc));
                exp_b_q.push_back(int_to_fp(xi[i]));
                acc = (op == 2'b01) ? acc - xi[i] : acc + xi[i];
                if (i == o_s) e_ovf = 1;
                if (i == u_s) e_unf = 1;
                if (i == e_s) begin e_exc = 1; break; end
            end
            exp_res = int_to_fp(acc);
            exp_lat = exp_req * (lat + 1) + 1;
        end

        @(posedge clk); #1;
        load_numbers();
        op_in = op; en = 1; start = 1;
        @(posedge clk); #1;
        start = 0;
        cyc = 1;
        while (data_valid !== 1'b1 && cyc < 2000) begin
            if (poke && cyc == 3) begin
                start = 1; op_in = 2'b10; numbers = '1;
            end else if (poke && cyc == 4) begin
                start = 0; op_in = op; load_numbers();
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 0;
        chk({name, ".latency"}, cyc, exp_lat);
        chk({name, ".result"}, result, exp_res);
        chk({name, ".ovf"}, ovf, e_ovf);
        chk({name, ".unf"}, unf, e_unf);
        chk({name, ".exc"}, exc, e_exc);
        chk({name, ".busy_done"}, busy, 1'b1);
        chk({name, ".nreq"}, got_a_q.size(), exp_req);
        for (int i = 0; i < exp_req && i < got_a_q.size(); i++) begin
            chk($sformatf("%s.req_a[%0d]", name, i), got_a_q[i], exp_a_q[i]);
            chk($sformatf("%s.req_b[%0d]", name, i), got_b_q[i], exp_b_q[i]);
        end
        held = result;
        @(posedge clk); #1;
        chk({name, ".valid_pulse"}, data_valid, 1'b0);
        chk({name, ".idle"}, busy, 1'b0);
        @(posedge clk); #1;
        chk({name, ".result_hold"}, result, held);
        chk({name, ".exc_hold"}, exc, e_exc);
    endtask

    task automatic check_all_zero(input string name);
        chk({name, ".busy"}, busy, 1'b0);
        chk({name, ".req"}, fpa_req, 1'b0);
        chk({name, ".a"}, fpa_a, 32'h0);
        chk({name, ".b"}, fpa_b, 32'h0);
        chk({name, ".op"}, fpa_op, 2'b00);
        chk({name, ".result"}, result, 32'h0);
        chk({name, ".flags"}, {ovf, unf, exc}, 3'b000);
        chk({name, ".dvalid"}, data_valid, 1'b0);
    endtask

    initial begin
        rst = 1; en = 0; start = 0; numbers = '0; op_in = 2'b00;
        late_pulse = 0; core_lat = 1; core_never = 0;
        ovf_step = 0; unf_step = 0; exc_step = 0; step = 0;
        #2;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // Start without enable must be ignored.
        for (int i = 0; i <= N; i++) xi[i] = 1;
        load_numbers();
        start = 1; en = 0;
        @(posedge clk); #1;
        start = 0;
        chk("no_en.busy", busy, 1'b0);

        for (int i = 0; i <= N; i++) xi[i] = 1;
        run_job("ones_add", 2'b00, 3, 0, 0, 0, 0, 0);
        xi[0] = 10;
        run_job("ten_sub", 2'b01, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i <= N; i++) xi[i] = i + 2;
        run_job("ovf4", 2'b00, 2, 4, 0, 0, 0, 0);
        run_job("exc3", 2'b00, 2, 0, 0, 3, 0, 0);
        run_job("unf_last", 2'b01, 1, 0, N, 0, 0, 0);
        run_job("timeout", 2'b00, 1, 0, 0, 0, 1, 0);
        run_job("valid_at_limit", 2'b01, TIMEOUT, 0, 0, 0, 0, 0);

        // Reset in the middle of a wait, then a stale response arrives.
        core_never = 1; step = 0;
        @(posedge clk); #1;
        load_numbers(); op_in = 2'b00; en = 1; start = 1;
        @(posedge clk); #1;
        start = 0;
        repeat (5) @(posedge clk);
        #1 rst = 1;
        #1 check_all_zero("mid_reset");
        @(posedge clk); #1;
        rst = 0;
        late_pulse = 1;
        repeat (4) @(posedge clk);
        #1 check_all_zero("late_valid");

        run_job("reserved10", 2'b10, 1, 0, 0, 0, 0, 0);
        run_job("reserved11", 2'b11, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i <= N; i++) xi[i] = 3 * i + 1;
        run_job("busy_poke", 2'b00, 2, 0, 0, 0, 0, 1);

        for (int t = 0; t < 15; t++) begin
            int r;
            for (int i = 0; i <= N; i++) xi[i] = $urandom_range(100);
            r = $urandom_range(9);
            run_job($sformatf("rand%0d", t),
                    (r == 0) ? 2'(2 + $urandom_range(1)) : 2'($urandom_range(1)),
                    $urandom_range(1, 5),
                    ($urandom_range(2) == 0) ? $urandom_range(1, N) : 0,
                    ($urandom_range(2) == 0) ? $urandom_range(1, N) : 0,
                    ($urandom_range(3) == 0) ? $urandom_range(1, N) : 0,
                    0, $urandom_range(1));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
